// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port arbiter in front of a single-ported data memory; port 1
//            (load/store) beats port 0 (fetch) unless DMEM_ARB_ROUND_ROBIN_EN
//            is defined, which alternates grants on contention.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int AW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [3:0]    m0_be,
    input  logic [31:0]   m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [3:0]    m1_be,
    input  logic [31:0]   m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam int            CW    = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] c_LAT = CW'(MEM_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_port, w_port_nxt;
    logic            w_sel;

    logic            r_mem_read, w_mem_read_nxt;
    logic            r_mem_write, w_mem_write_nxt;
    logic [AW-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [3:0]      r_mem_be, w_mem_be_nxt;
    logic [31:0]     r_mem_wdata, w_mem_wdata_nxt;
    logic            r_m0_gnt, w_m0_gnt_nxt;
    logic            r_m1_gnt, w_m1_gnt_nxt;
    logic            r_m0_rvalid, w_m0_rvalid_nxt;
    logic            r_m1_rvalid, w_m1_rvalid_nxt;
    logic [31:0]     r_m0_rdata, w_m0_rdata_nxt;
    logic [31:0]     r_m1_rdata, w_m1_rdata_nxt;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // r_last remembers the most recent winner; 0 after reset so port 1 wins first.
    logic r_last;

    assign w_sel = (m0_req & m1_req) ? ~r_last : m1_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b0;
        end else if ((r_state == S_IDLE) && (m0_req | m1_req)) begin
            r_last <= w_sel;
        end
    end
`else
    assign w_sel = m1_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_port      <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_m0_gnt    <= 1'b0;
            r_m1_gnt    <= 1'b0;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_port      <= w_port_nxt;
            r_mem_read  <= w_mem_read_nxt;
            r_mem_write <= w_mem_write_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_be    <= w_mem_be_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_m0_gnt    <= w_m0_gnt_nxt;
            r_m1_gnt    <= w_m1_gnt_nxt;
            r_m0_rvalid <= w_m0_rvalid_nxt;
            r_m1_rvalid <= w_m1_rvalid_nxt;
            r_m0_rdata  <= w_m0_rdata_nxt;
            r_m1_rdata  <= w_m1_rdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_port_nxt      = r_port;
        w_mem_read_nxt  = 1'b0;
        w_mem_write_nxt = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_be_nxt    = r_mem_be;
        w_mem_wdata_nxt = r_mem_wdata;
        w_m0_gnt_nxt    = 1'b0;
        w_m1_gnt_nxt    = 1'b0;
        w_m0_rvalid_nxt = 1'b0;
        w_m1_rvalid_nxt = 1'b0;
        w_m0_rdata_nxt  = r_m0_rdata;
        w_m1_rdata_nxt  = r_m1_rdata;

        unique case (r_state)
            S_IDLE: begin
                if (m0_req | m1_req) begin
                    w_port_nxt  = w_sel;
                    w_state_nxt = S_ISSUE;
                    if (w_sel) begin
                        w_mem_addr_nxt  = m1_addr;
                        w_mem_be_nxt    = m1_be;
                        w_mem_wdata_nxt = m1_wdata;
                        w_mem_read_nxt  = ~m1_we;
                        w_mem_write_nxt = m1_we;
                        w_m1_gnt_nxt    = 1'b1;
                    end else begin
                        w_mem_addr_nxt  = m0_addr;
                        w_mem_be_nxt    = m0_be;
                        w_mem_wdata_nxt = m0_wdata;
                        w_mem_read_nxt  = ~m0_we;
                        w_mem_write_nxt = m0_we;
                        w_m0_gnt_nxt    = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (r_mem_write) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = CW'(1);
                end
            end
            S_WAIT: begin
                // mem_rdata is valid in the cycle where the count reaches MEM_LAT.
                if (r_cnt == c_LAT) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    if (r_port) begin
                        w_m1_rdata_nxt  = mem_rdata;
                        w_m1_rvalid_nxt = 1'b1;
                    end else begin
                        w_m0_rdata_nxt  = mem_rdata;
                        w_m0_rvalid_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign m0_gnt    = r_m0_gnt;
    assign m1_gnt    = r_m1_gnt;
    assign m0_rvalid = r_m0_rvalid;
    assign m1_rvalid = r_m1_rvalid;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed scoreboard bench for dmem_arbiter (MEM_LAT = 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int AW      = 32;
    localparam int MEM_LAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [3:0]    m0_be, m1_be;
    logic [31:0]   m0_wdata, m1_wdata;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata, mem_rdata;

    dmem_arbiter #(.AW(AW), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_be(m0_be),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_be(m1_be),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } gexp_t;

    typedef struct {
        bit          port;
        logic [31:0] data;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    cyc   = 0;
    int    last_gcyc[2];
    int    prev_gcyc = -1000;
    bit    prev_we   = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'hDEADBEEF + (a - 32'h10);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory model: read data is valid only in cycle T+MEM_LAT, garbage otherwise.
    initial begin : mem_model
        int          age;
        bit          pend;
        logic [31:0] paddr;
        pend      = 1'b0;
        age       = 0;
        paddr     = '0;
        mem_rdata = 32'hBAD0BAD0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                pend = 1'b0;
            end else if (mem_read) begin
                pend  = 1'b1;
                age   = 0;
                paddr = mem_addr;
            end else if (pend) begin
                age++;
            end
            if (pend && age == MEM_LAT) begin
                mem_rdata = memf(paddr);
                pend      = 1'b0;
            end else begin
                mem_rdata = 32'hBAD0BAD0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a grant or read data.
    always @(negedge clk) begin : monitor
        gexp_t g;
        rexp_t r;
        bit    p;
        if (mem_read | mem_write | m0_gnt | m1_gnt) begin
            chk("strobe_vs_gnt", {62'd0, (mem_read | mem_write), (mem_read & mem_write)},
                {62'd0, (m0_gnt | m1_gnt), 1'b0});
        end
        if (m0_gnt | m1_gnt) begin
            p = m1_gnt;
            chk("single_gnt", {63'd0, (m0_gnt & m1_gnt)}, 64'd0);
            if (gq.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_gnt: got port%0d gnt expected none", p);
            end else begin
                g = gq.pop_front();
                chk("gnt_port", {63'd0, p}, {63'd0, g.port});
                chk("gnt_kind", {62'd0, mem_write, mem_read}, {62'd0, g.we, ~g.we});
                chk("gnt_addr_be", {28'd0, mem_be, mem_addr}, {28'd0, g.be, g.addr});
                if (g.we) chk("gnt_wdata", {32'd0, mem_wdata}, {32'd0, g.wdata});
            end
            chk("gnt_spacing_ok",
                {63'd0, (cyc - prev_gcyc) >= (prev_we ? 2 : MEM_LAT + 2)}, 64'd1);
            last_gcyc[p] = cyc;
            prev_gcyc    = cyc;
            prev_we      = mem_write;
        end
        if (m0_rvalid | m1_rvalid) begin
            p = m1_rvalid;
            chk("single_rvalid", {63'd0, (m0_rvalid & m1_rvalid)}, 64'd0);
            if (rq.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_rvalid: got port%0d rvalid expected none", p);
            end else begin
                r = rq.pop_front();
                chk("rvalid_port", {63'd0, p}, {63'd0, r.port});
                chk("rdata", {32'd0, (p ? m1_rdata : m0_rdata)}, {32'd0, r.data});
                chk("rvalid_latency", 64'(cyc - last_gcyc[p]), 64'(MEM_LAT + 1));
            end
        end
    end

    task automatic drive(input bit p, input bit req, input bit we, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        if (p) begin
            m1_req = req; m1_we = we; m1_addr = a; m1_be = be; m1_wdata = wd;
        end else begin
            m0_req = req; m0_we = we; m0_addr = a; m0_be = be; m0_wdata = wd;
        end
    endtask

    task automatic wait_gnt(input bit p, output int gc);
        gc = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (p ? m1_gnt : m0_gnt) begin
                gc = cyc;
                break;
            end
        end
        if (gc < 0) begin
            n_vec++; n_err++;
            $display("FAIL gnt_timeout: got no gnt on port%0d expected one within 60 cycles", p);
        end
    endtask

    // Raise a request now, wait for its grant, drop req on the following cycle.
    task automatic do_req(input bit p, input bit we, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd, output int gc);
        drive(p, 1'b1, we, a, be, wd);
        wait_gnt(p, gc);
        @(posedge clk); #2;
        if (p) m1_req = 1'b0; else m0_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_g(input bit p, input bit we, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
        gexp_t g;
        g.port = p; g.we = we; g.addr = a; g.be = be; g.wdata = wd;
        gq.push_back(g);
    endtask

    task automatic push_r(input bit p, input logic [31:0] d);
        rexp_t r;
        r.port = p; r.data = d;
        rq.push_back(r);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got no end of test expected finish before 300000");
        $fatal(1);
    end

    initial begin : stim
        int g0, g1, gw, gr, cnt;
        bit order[4];
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {58'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_read, mem_write}, 64'd0);
        chk("rst_bus", {28'd0, mem_be, mem_addr}, 64'd0);
        chk("rst_rdata", {m1_rdata, m0_rdata}, 64'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        idle(2);

        // Single port-1 read
        push_g(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        push_r(1'b1, 32'hDEADBEEF);
        do_req(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, g1);
        idle(MEM_LAT + 3);
        chk("t1_rdata_hold", {m1_rdata, m0_rdata}, {32'hDEADBEEF, 32'h0});

        // Port-0 write, then port-0 read as early as allowed
        push_g(1'b0, 1'b1, 32'h20, 4'b0011, 32'h1234);
        push_g(1'b0, 1'b0, 32'h24, 4'hF, 32'h0);
        push_r(1'b0, memf(32'h24));
        do_req(1'b0, 1'b1, 32'h20, 4'b0011, 32'h1234, gw);
        do_req(1'b0, 1'b0, 32'h24, 4'hF, 32'h0, gr);
        chk("t2_wr_to_rd", 64'(gr - gw), 64'd2);
        idle(MEM_LAT + 3);
        chk("t2_other_rdata", {32'd0, m1_rdata}, {32'd0, 32'hDEADBEEF});

        // Simultaneous reads: port 1 first, port 0 after the read turnaround
        push_g(1'b1, 1'b0, 32'h34, 4'hF, 32'h0);
        push_g(1'b0, 1'b0, 32'h30, 4'hF, 32'h0);
        push_r(1'b1, memf(32'h34));
        push_r(1'b0, memf(32'h30));
        fork
            do_req(1'b1, 1'b0, 32'h34, 4'hF, 32'h0, g1);
            do_req(1'b0, 1'b0, 32'h30, 4'hF, 32'h0, g0);
        join
        chk("t3_turnaround", 64'(g0 - g1), 64'(MEM_LAT + 2));
        idle(MEM_LAT + 3);

        // Both requesters held for four write grants
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int i = 0; i < 4; i++) begin
            if (order[i]) push_g(1'b1, 1'b1, 32'h200, 4'hC, 32'hB1);
            else          push_g(1'b0, 1'b1, 32'h100, 4'hF, 32'hA0);
        end
        drive(1'b0, 1'b1, 1'b1, 32'h100, 4'hF, 32'hA0);
        drive(1'b1, 1'b1, 1'b1, 32'h200, 4'hC, 32'hB1);
        cnt = 0;
        for (int k = 0; k < 40 && cnt < 4; k++) begin
            @(negedge clk);
            if (m0_gnt | m1_gnt) cnt++;
        end
        chk("t4_grant_count", 64'(cnt), 64'd4);
        @(posedge clk); #2;
        m0_req = 1'b0;
        m1_req = 1'b0;
        idle(4);

        // Reset in the cycle after a read issue aborts it
        push_g(1'b0, 1'b0, 32'h40, 4'hF, 32'h0);
        do_req(1'b0, 1'b0, 32'h40, 4'hF, 32'h0, g0);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_ctrl", {58'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_read, mem_write}, 64'd0);
        chk("t5_rst_bus", {28'd0, mem_be, mem_addr}, 64'd0);
        chk("t5_rst_rdata", {m1_rdata, m0_rdata}, 64'd0);
        idle(MEM_LAT + 3);
        push_g(1'b0, 1'b0, 32'h44, 4'hF, 32'h0);
        push_r(1'b0, memf(32'h44));
        do_req(1'b0, 1'b0, 32'h44, 4'hF, 32'h0, g0);
        idle(MEM_LAT + 3);

        // Requester changes its address after grant
        push_g(1'b0, 1'b0, 32'h50, 4'h3, 32'h0);
        push_r(1'b0, memf(32'h50));
        do_req(1'b0, 1'b0, 32'h50, 4'h3, 32'h0, g0);
        m0_addr = 32'h99;
        for (int k = 0; k < MEM_LAT; k++) begin
            @(negedge clk);
            chk("t6_addr_held", {32'd0, mem_addr}, {32'd0, 32'h50});
        end
        idle(MEM_LAT + 3);
        chk("t6_rdata", {m1_rdata, m0_rdata}, {32'h0, memf(32'h50)});

        chk("gq_drained", 64'(gq.size()), 64'd0);
        chk("rq_drained", 64'(rq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported data memory between two requesters: port 0 (instruction fetch) and port 1 (ALU load/store path).
- Accepts one request at a time, drives the memory strobes for exactly one cycle, and waits out a fixed memory read latency.
- Returns read data to the winning port with a one-cycle valid pulse.
- Sits between the core's fetch/execute logic and the data memory; replaces direct ALU-to-memory wiring.

Parameters:
- AW, 32, address width of all address ports.
- MEM_LAT, 1, cycles from the mem_read strobe cycle to valid mem_rdata (≥1).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- m0_req  input  1  port 0 request, held until m0_gnt
- m0_we  input  1  port 0 write (1) / read (0)
- m0_addr  input  AW  port 0 byte address
- m0_be  input  4  port 0 byte enables
- m0_wdata  input  32  port 0 write data
- m0_gnt  output  1  port 0 grant pulse
- m0_rvalid  output  1  port 0 read data valid pulse
- m0_rdata  output  32  port 0 read data
- m1_req, m1_we, m1_addr, m1_be, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_addr  output  AW  memory address
- mem_be  output  4  memory byte enables
- mem_wdata  output  32  memory write data
- mem_rdata  input  32  memory read data

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, wait counter 0, round-robin pointer 0.
- FSM states: IDLE, ISSUE, WAIT. All outputs are registered.
- IDLE:
  - If any req is high, select a winner and latch its we/addr/be/wdata into the mem_* registers.
  - Set mem_read=!we or mem_write=we, pulse the winner's gnt, and go to ISSUE.
  - With no req, stay in IDLE with strobes low.
- ISSUE (exactly 1 cycle; call it cycle T):
  - mem strobe high and gnt high during this cycle only; both are cleared on exit.
  - On a write, go to IDLE.
  - On a read, go to WAIT with cnt=1.
- WAIT:
  - While cnt<MEM_LAT, increment cnt each cycle.
  - When cnt==MEM_LAT (cycle T+MEM_LAT), capture mem_rdata into the winner's rdata and set its rvalid for cycle T+MEM_LAT+1 only. Go to IDLE.
- Timing:
  - Read: gnt at T, rvalid at T+MEM_LAT+1.
  - Write: next ISSUE no earlier than T+2.
  - Read turnaround: next ISSUE no earlier than T+MEM_LAT+2. IDLE may accept a new request in the same cycle that rvalid is high.
- Fields are latched at grant. A requester may change or drop its fields after gnt. A req still high after gnt counts as a new request.
- mX_rdata holds its last captured value until the next read completes for that port. The other port's rdata is unchanged.
- A req that drops before grant is never serviced; no gnt is issued.
- Contention: port 1 (data) has fixed priority over port 0 (fetch).
- Requests arriving in ISSUE or WAIT are ignored until IDLE.
- addr and be pass through unchanged. No alignment check is done.
- Reset mid-operation: the in-flight access is aborted with no rvalid. mem strobes, gnt and rvalid are low the cycle after rst is sampled.

Optional Feature:
- Macro: DMEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last-grant pointer updates on every grant.
  - On simultaneous requests, the port not granted last wins.
  - A single requester always wins regardless of the pointer.
  - Pointer resets to 0, so port 1 wins the first contention.
- Undefined: fixed priority, port 1 over port 0, and no pointer register.

Test Plan:
- MEM_LAT=1, m1 read addr=0x10, mem_rdata=0xDEADBEEF → m1_gnt and mem_read at T; m1_rvalid=1 with m1_rdata=0xDEADBEEF at T+2; m0 outputs stay 0.
- m0 write addr=0x20, be=4'b0011, wdata=0x1234 → mem_write=1, mem_addr=0x20, mem_be=0011 for one cycle; no rvalid; m0 read accepted at T+2.
- MEM_LAT=3, m0 and m1 reads held together, fixed priority → m1 gnt at T, m1_rvalid at T+4, m0 gnt at T+5.
- DMEM_ARB_ROUND_ROBIN_EN defined, both reqs held continuously for 4 grants → grant order m1, m0, m1, m0.
- MEM_LAT=3, rst=1 in the cycle after a read ISSUE → no rvalid, all outputs 0; a fresh m0 read after reset completes normally.
- m0 read issued, m0 addr changed the cycle after gnt → mem_addr keeps the original value for the whole access.
